seg_scan_ctrl: RTL and testbench
================================

// Module: seg_scan_ctrl
// PURPOSE
//  Scan scheduler for the 8-digit 7-seg display behind the HC595 shift chain.
//  Snapshots a 32-bit hex word, walks digits 0..7 at a fixed scan rate, decodes
//  each nibble to segments and hands one 16-bit frame per digit to the HC595
//  serializer over a valid/ready handshake. Sits between app logic and the
//  sh_cp/st_cp/ds engine; the serializer owns all pin timing.
// PARAMETERS
//  CLK_FREQ        50_000_000  input clock, Hz
//  SCAN_HZ         1000        digit-step rate, Hz; TICK_DIV = CLK_FREQ/SCAN_HZ
//  SEG_ACTIVE_LOW  1           1: segment bit 0 = lit (common-anode)
//  SEL_ACTIVE_LOW  1           1: digit-select bit 0 = selected
// PORTS
//  clk          in   1   system clock, 50 MHz
//  reset        in   1   synchronous, active-high
//  disp_data    in   32  digit i = disp_data[4i+3:4i], digit 0 rightmost
//  disp_en      in   8   per-digit enable; 0 = digit blanked
//  frame_data   out  16  [15:8] seg {dp,g,f,e,d,c,b,a}; [7:0] one-hot select
//  frame_valid  out  1   frame_data valid; held until frame_ready
//  frame_ready  in   1   serializer accepts frame this cycle
//  digit_idx    out  3   digit of the current/last frame
//  overrun      out  1   1-cycle pulse: tick arrived while a frame was unaccepted
// BEHAVIOUR
//  - Reset (sync): FSM=WAIT, tick_cnt=0, digit_idx=0, frame_valid=0,
//    frame_data=16'hFFFF if both polarities active-low (all off), overrun=0.
//  - tick_cnt counts 0..TICK_DIV-1; tick = 1-cycle pulse at wrap.
//  - FSM: WAIT -(tick)-> LOAD -> SEND -(frame_valid&frame_ready)-> WAIT.
//    LOAD: if digit_idx==0, latch disp_data/disp_en into snapshot (frame-coherent
//    update; mid-scan changes appear from next digit 0). Decode, build frame.
//    SEND: frame_valid=1, frame_data stable until accepted.
//    On accept: frame_valid=0 next cycle; digit_idx increments mod 8 (7 -> 0).
//  - Latency: frame_valid rises 2 cycles after tick (LOAD, then SEND).
//  - tick while in LOAD/SEND: tick dropped, overrun pulses, digit not advanced;
//    current frame stays valid. Tick coincident with accept: same rule.
//  - Disabled digit: frame still sent (uniform timing), seg = all off, select =
//    that digit.
//  - Decode (active-low): 0 C0,1 F9,2 A4,3 B0,4 99,5 92,6 82,7 F8,8 80,9 90,
//    A 88,b 83,C C6,d A1,E 86,F 8E; dp always off. Polarity params invert.
//  - Reset mid-SEND: frame dropped, frame_valid low after the reset edge;
//    serializer must tolerate an unaccepted frame vanishing.
// CONFIGURATION
//  SEG_ZERO_BLANK_EN defined: leading-zero blanking over the snapshot -- digits
//    above the highest nonzero nibble are blanked as if disp_en=0; digit 0 is
//    never blanked (value 0 shows "0").
//  Not defined: every enabled digit shows its nibble, zeros included.
// STRUCTURE
//  Shared package seg_pkg: 16-entry active-low segment table, SEG_OFF=8'hFF,
//  frame field offsets, FSM state enum {WAIT,LOAD,SEND}.
//  Sub-module hex2seg: 4-bit nibble + blank + polarity -> 8-bit segments,
//  combinational, reused by other display blocks.
// TESTING (CLK_FREQ=1000, SCAN_HZ=100 -> tick every 10 clk)
//  1 disp_data=32'h12345678, en=FF, ready=1 -> frames 80FE,F8FD,82FB,92F7,
//    99EF,B0DF,A4BF,F97F, then repeats from 80FE.
//  2 ready held 0 for 30 clk in SEND -> frame_data/valid stable, overrun pulses
//    at each of the 3 ticks, digit_idx unchanged; accept -> next digit.
//  3 disp_data changed to 32'h87654321 while digit_idx=3 -> digits 3..7 still
//    old values; new word appears from next digit 0 (frame F9FE).
//  4 disp_en=8'h0F, data 32'h89ABCDEF -> digits 4..7 send FF with selects
//    EF,DF,BF,7F; digits 0..3 send 8E,86,A1,C6.
//  5 SEG_ZERO_BLANK_EN, data 32'h00000042 -> digits 2..7 seg FF, d0=A4, d1=99;
//    data 0 -> digit 0 = C0, rest FF. Without macro: zeros show C0.
//  6 reset asserted one cycle while frame_valid=1 -> next edge all outputs at
//    reset values, scan restarts at digit 0 after next tick.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment display blocks: segment table,
// frame field offsets and the scan FSM state type.
package seg_pkg;

   localparam logic [7:0]  SEG_OFF       = 8'hFF;
   localparam int unsigned FRAME_SEG_LSB = 8;
   localparam int unsigned FRAME_SEL_LSB = 0;

   typedef enum logic [1:0] {
      WAIT,
      LOAD,
      SEND
   } scan_state_t;

   // Active-low {dp,g,f,e,d,c,b,a}; dp is always off.
   function automatic logic [7:0] seg_decode(input logic [3:0] nibble);
      logic [7:0] seg;
      case (nibble)
         4'h0:    seg = 8'hC0;
         4'h1:    seg = 8'hF9;
         4'h2:    seg = 8'hA4;
         4'h3:    seg = 8'hB0;
         4'h4:    seg = 8'h99;
         4'h5:    seg = 8'h92;
         4'h6:    seg = 8'h82;
         4'h7:    seg = 8'hF8;
         4'h8:    seg = 8'h80;
         4'h9:    seg = 8'h90;
         4'hA:    seg = 8'h88;
         4'hB:    seg = 8'h83;
         4'hC:    seg = 8'hC6;
         4'hD:    seg = 8'hA1;
         4'hE:    seg = 8'h86;
         default: seg = 8'h8E;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/seg_scan_ctrl_hex2seg.sv
// Combinational hex nibble to 7-segment decoder with blanking and
// selectable segment polarity.
module hex2seg
   import seg_pkg::*;
#(
   parameter bit SEG_ACTIVE_LOW = 1'b1
) (
   input  logic [3:0] nibble,
   input  logic       blank,
   output logic [7:0] seg
);

   logic [7:0] seg_low;

   always_comb begin
      seg_low = blank ? SEG_OFF : seg_decode(nibble);
      seg     = SEG_ACTIVE_LOW ? seg_low : ~seg_low;
   end

endmodule

// File: rtl/seg_scan_ctrl.sv
// 8-digit 7-segment scan scheduler feeding an HC595 serializer frame by frame.
// Optional leading-zero blanking when SEG_ZERO_BLANK_EN is defined.
module seg_scan_ctrl #(
   parameter int CLK_FREQ       = 50_000_000,
   parameter int SCAN_HZ        = 1000,
   parameter int SEG_ACTIVE_LOW = 1,
   parameter int SEL_ACTIVE_LOW = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] disp_data,
   input  logic [7:0]  disp_en,
   output logic [15:0] frame_data,
   output logic        frame_valid,
   input  logic        frame_ready,
   output logic [2:0]  digit_idx,
   output logic        overrun
);
   import seg_pkg::*;

   localparam int unsigned TICK_DIV = CLK_FREQ / SCAN_HZ;
   localparam int unsigned CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
   localparam logic [7:0]  SEG_BLANK  = (SEG_ACTIVE_LOW != 0) ? SEG_OFF : ~SEG_OFF;
   localparam logic [7:0]  SEL_NONE   = (SEL_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
   localparam logic [15:0] FRAME_IDLE = {SEG_BLANK, SEL_NONE};

   logic [CNT_W-1:0] tick_cnt;
   logic             tick;
   scan_state_t      state, state_next;
   logic [31:0]      snap_data, src_data;
   logic [7:0]       snap_en, src_en;
   logic [3:0]       cur_nibble;
   logic             zero_blank, digit_blank;
   logic [7:0]       seg_bits, sel_onehot, sel_bits;
   logic             accept;

   always_comb tick = (tick_cnt == TICK_LAST);

   always_ff @(posedge clk) begin
      if (reset || tick) tick_cnt <= '0;
      else               tick_cnt <= tick_cnt + 1'b1;
   end

   // Digit 0 is built in the same LOAD cycle that takes the snapshot, so it
   // decodes straight from the live inputs.
   always_comb begin
      src_data    = (digit_idx == 3'd0) ? disp_data : snap_data;
      src_en      = (digit_idx == 3'd0) ? disp_en   : snap_en;
      cur_nibble  = src_data[{digit_idx, 2'b00} +: 4];
      digit_blank = ~src_en[digit_idx] | zero_blank;
      sel_onehot  = 8'b1 << digit_idx;
      sel_bits    = (SEL_ACTIVE_LOW != 0) ? ~sel_onehot : sel_onehot;
      accept      = frame_valid & frame_ready;
   end

`ifdef SEG_ZERO_BLANK_EN
   logic [2:0] top_nz;

   always_comb begin
      top_nz = '0;
      for (int unsigned i = 1; i < 8; i++) begin
         if (src_data[4*i +: 4] != 4'h0) top_nz = 3'(i);
      end
      zero_blank = (digit_idx > top_nz);
   end
`else
   always_comb zero_blank = 1'b0;
`endif

   hex2seg #(
      .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW != 0)
   ) u_hex2seg (
      .nibble(cur_nibble),
      .blank (digit_blank),
      .seg   (seg_bits)
   );

   always_comb begin
      state_next  = state;
      frame_valid = (state == SEND);
      case (state)
         WAIT:    if (tick) state_next = LOAD;
         LOAD:    state_next = SEND;
         SEND:    if (accept) state_next = WAIT;
         default: state_next = WAIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= WAIT;
         digit_idx  <= '0;
         frame_data <= FRAME_IDLE;
         overrun    <= 1'b0;
         snap_data  <= '0;
         snap_en    <= '0;
      end else begin
         state   <= state_next;
         overrun <= tick && (state != WAIT);
         if (state == LOAD) begin
            frame_data[FRAME_SEG_LSB +: 8] <= seg_bits;
            frame_data[FRAME_SEL_LSB +: 8] <= sel_bits;
            if (digit_idx == 3'd0) begin
               snap_data <= disp_data;
               snap_en   <= disp_en;
            end
         end
         if (accept) digit_idx <= digit_idx + 3'd1;
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed-vector bench for seg_scan_ctrl (tick every 10 clk).
// Define SEG_ZERO_BLANK_EN for both bench and RTL to test blanking.
module tb_seg_scan_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] disp_data;
   logic [7:0]  disp_en;
   logic [15:0] frame_data;
   logic        frame_valid;
   logic        frame_ready;
   logic [2:0]  digit_idx;
   logic        overrun;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   always #5 clk = ~clk;

   seg_scan_ctrl #(
      .CLK_FREQ      (1000),
      .SCAN_HZ       (100),
      .SEG_ACTIVE_LOW(1),
      .SEL_ACTIVE_LOW(1)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .disp_data  (disp_data),
      .disp_en    (disp_en),
      .frame_data (frame_data),
      .frame_valid(frame_valid),
      .frame_ready(frame_ready),
      .digit_idx  (digit_idx),
      .overrun    (overrun)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Waits (bounded) for a valid frame, samples it, then lets one edge pass.
   task automatic get_frame(input string tag, output logic [15:0] fd,
                            output logic [2:0] idx, output int unsigned lat);
      lat = 0;
      while (lat < 40) begin
         @(negedge clk);
         lat++;
         if (frame_valid) break;
      end
      check({tag, "_valid"}, 32'(frame_valid), 32'd1);
      fd  = frame_data;
      idx = digit_idx;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic expect_frame(input string tag, input logic [15:0] exp_fd, input logic [2:0] exp_idx);
      logic [15:0] fd;
      logic [2:0]  idx;
      int unsigned lat;
      get_frame(tag, fd, idx, lat);
      check({tag, "_data"}, 32'(fd), 32'(exp_fd));
      check({tag, "_idx"}, 32'(idx), 32'(exp_idx));
   endtask

   function automatic logic [7:0] sel_of(input int unsigned d);
      logic [7:0] one;
      one = 8'b1 << d;
      return ~one;
   endfunction

   logic [15:0] exp1 [8] = '{16'h80FE, 16'hF8FD, 16'h82FB, 16'h92F7,
                             16'h99EF, 16'hB0DF, 16'hA4BF, 16'hF97F};
`ifdef SEG_ZERO_BLANK_EN
   logic [7:0] zseg = 8'hFF;
`else
   logic [7:0] zseg = 8'hC0;
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] fd, held;
      logic [2:0]  idx;
      int unsigned lat, ovr, unstable;
      logic [15:0] exp4 [8] = '{16'h8EFE, 16'h86FD, 16'hA1FB, 16'hC6F7,
                                16'hFFEF, 16'hFFDF, 16'hFFBF, 16'hFF7F};

      reset = 1'b1; frame_ready = 1'b0;
      disp_data = 32'h12345678; disp_en = 8'hFF;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_valid", 32'(frame_valid), 32'd0);
      check("rst_data", 32'(frame_data), 32'hFFFF);
      check("rst_idx", 32'(digit_idx), 32'd0);
      check("rst_ovr", 32'(overrun), 32'd0);

      // 1: full scan with ready high, wrap back to digit 0
      reset = 1'b0; frame_ready = 1'b1;
      get_frame("t1_first", fd, idx, lat);
      check("t1_latency", lat, 32'd11);
      check("t1_d0", 32'(fd), 32'h80FE);
      for (int i = 1; i < 9; i++) expect_frame($sformatf("t1_d%0d", i), exp1[i % 8], 3'(i % 8));

      // 2: backpressure for 30 clk, three dropped ticks
      frame_ready = 1'b0;
      get_frame("t2_hold", held, idx, lat);
      check("t2_data", 32'(held), 32'hF8FD);
      ovr = 0; unstable = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (overrun) ovr++;
         if (!frame_valid || frame_data != held) unstable++;
      end
      check("t2_overruns", ovr, 32'd3);
      check("t2_unstable", unstable, 32'd0);
      check("t2_idx", 32'(digit_idx), 32'd1);
      frame_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      expect_frame("t2_next", 16'h82FB, 3'd2);

      // 3: mid-scan data change only takes effect at the next digit 0
      check("t3_idx", 32'(digit_idx), 32'd3);
      disp_data = 32'h87654321;
      for (int i = 3; i < 8; i++) expect_frame($sformatf("t3_d%0d", i), exp1[i], 3'(i));
      expect_frame("t3_new0", 16'hF9FE, 3'd0);
      expect_frame("t3_new1", 16'hA4FD, 3'd1);

      // 4: disabled upper digits (old snapshot drains first)
      disp_data = 32'h89ABCDEF; disp_en = 8'h0F;
      expect_frame("t4_old2", 16'hB0FB, 3'd2);
      expect_frame("t4_old3", 16'h99F7, 3'd3);
      expect_frame("t4_old4", 16'h92EF, 3'd4);
      expect_frame("t4_old5", 16'h82DF, 3'd5);
      expect_frame("t4_old6", 16'hF8BF, 3'd6);
      expect_frame("t4_old7", 16'h807F, 3'd7);
      for (int i = 0; i < 8; i++) expect_frame($sformatf("t4_d%0d", i), exp4[i], 3'(i));

      // 5: zeros, with or without leading-zero blanking
      disp_data = 32'h00000042; disp_en = 8'hFF;
      expect_frame("t5_d0", 16'hA4FE, 3'd0);
      expect_frame("t5_d1", 16'h99FD, 3'd1);
      for (int i = 2; i < 8; i++) expect_frame($sformatf("t5_d%0d", i), {zseg, sel_of(i)}, 3'(i));
      disp_data = 32'h0;
      expect_frame("t5_z0", 16'hC0FE, 3'd0);
      for (int i = 1; i < 8; i++) expect_frame($sformatf("t5_z%0d", i), {zseg, sel_of(i)}, 3'(i));

      // 6: reset while a frame is pending
      frame_ready = 1'b0;
      get_frame("t6_pend", fd, idx, lat);
      check("t6_pend_data", 32'(fd), 32'hC0FE);
      reset = 1'b1;
      @(negedge clk);
      check("t6_valid", 32'(frame_valid), 32'd0);
      check("t6_data", 32'(frame_data), 32'hFFFF);
      check("t6_idx", 32'(digit_idx), 32'd0);
      check("t6_ovr", 32'(overrun), 32'd0);
      reset = 1'b0; frame_ready = 1'b1;
      get_frame("t6_restart", fd, idx, lat);
      check("t6_latency", lat, 32'd11);
      check("t6_rdata", 32'(fd), 32'hC0FE);
      check("t6_ridx", 32'(idx), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
